// File: rtl/qif_neuron_array.sv
// Time-multiplexed quadratic integrate-and-fire neuron array.
// One channel is updated per enabled cycle; results are registered and
// reported one cycle later together with a per-sweep spike vector.
module qif_neuron_array #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int QSHIFT   = 8,
    parameter int LEAK     = 0,
    parameter int REFRAC   = 2,
    parameter int V_RESET  = 0,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CHANNELS*WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0]          thresh_in,
    output logic [WIDTH-1:0]          v_out,
    output logic [CH_W-1:0]           ch_out,
    output logic                      out_valid,
    output logic                      spike_out,
    output logic                      sweep_done,
    output logic [CHANNELS-1:0]       spike_vec
);

    // Refractory counter must hold REFRAC; sum width covers V + V*V + b
    // without any truncation.
    localparam int R_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int S_W = 2 * WIDTH + 2;

    localparam logic [WIDTH-1:0] V_RST     = WIDTH'(V_RESET);
    localparam logic [R_W-1:0]   R_LOAD    = R_W'(REFRAC);
    localparam logic [S_W-1:0]   LEAK_S    = S_W'(LEAK);
    localparam logic [CH_W-1:0]  PTR_LAST  = CH_W'(CHANNELS - 1);

    logic [WIDTH-1:0]    r_v [CHANNELS];
    logic [R_W-1:0]      r_r [CHANNELS];
    logic [CH_W-1:0]     r_ptr;
    logic [CHANNELS-1:0] r_coll;

    logic [WIDTH-1:0]    w_v_cur;
    logic [R_W-1:0]      w_r_cur;
    logic [WIDTH-1:0]    w_b;
    logic [S_W-1:0]      w_sq;
    logic [S_W-1:0]      w_sum;
    logic [S_W-1:0]      w_leaked;
    logic                w_refrac;
    logic                w_spike;
    logic [WIDTH-1:0]    w_v_next;
    logic [R_W-1:0]      w_r_next;
    logic                w_last;
    logic [CH_W-1:0]     w_ptr_next;
    logic [CHANNELS-1:0] w_coll_next;

    // Datapath for the channel selected by the pointer.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_v_cur     = r_v[r_ptr];
        w_r_cur     = r_r[r_ptr];
        w_b         = b_in[r_ptr*WIDTH +: WIDTH];
        w_sq        = S_W'(w_v_cur) * S_W'(w_v_cur);
        w_sum       = S_W'(w_v_cur) + (w_sq >> QSHIFT) + S_W'(w_b);
        w_leaked    = (w_sum > LEAK_S) ? (w_sum - LEAK_S) : '0;
        w_refrac    = (w_r_cur != '0);
        w_spike     = !w_refrac && (w_leaked >= S_W'(thresh_in));
        w_v_next    = w_leaked[WIDTH-1:0];
        w_r_next    = '0;
        if (w_refrac) begin
            w_v_next = V_RST;
            w_r_next = w_r_cur - 1'b1;
        end else if (w_spike) begin
            w_v_next = V_RST;
            w_r_next = R_LOAD;
        end
        w_last      = (r_ptr == PTR_LAST);
        w_ptr_next  = w_last ? '0 : r_ptr + 1'b1;
        w_coll_next = r_coll | (CHANNELS'(w_spike) << r_ptr);
    end

    // Per-channel membrane/refractory state, pointer and spike collection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the state arrays are reset explicitly so every channel restarts clean; they stay in flops.
            for (int k = 0; k < CHANNELS; k++) begin
                r_v[k] <= V_RST;
                r_r[k] <= '0;
            end
            r_ptr  <= '0;
            r_coll <= '0;
        end else if (en) begin
            // NOTE: state uses non-blocking assignments so all registers see pre-edge values.
            r_v[r_ptr] <= w_v_next;
            r_r[r_ptr] <= w_r_next;
            r_ptr      <= w_ptr_next;
            r_coll     <= w_last ? '0 : w_coll_next;
        end
    end

    // Registered report of the update performed this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_out      <= '0;
            ch_out     <= '0;
            out_valid  <= 1'b0;
            spike_out  <= 1'b0;
            sweep_done <= 1'b0;
            spike_vec  <= '0;
        end else begin
            out_valid  <= en;
            spike_out  <= en && w_spike;
            sweep_done <= en && w_last;
            if (en) begin
                v_out  <= w_v_next;
                ch_out <= r_ptr;
                if (w_last) begin
                    spike_vec <= w_coll_next;
                end
            end
        end
    end

endmodule
